decode_execute_register: RTL and testbench

- Pipeline register between the decode stage (register file, control decoder, extender) and the execute stage of the 24-bit pipelined core.
- Captures decode operands and control signals each cycle and supports stall (hold) and flush (bubble insertion).
- Provides a writeback-to-decode bypass so a register written on the same edge is not captured stale.
- Keeps saturating stall/flush event counters for the performance debug path.

---
 rtl/decode_pkg.sv | 24 ++
 rtl/operand_bypass_mux.sv | 35 +++
 rtl/decode_execute_register.sv | 148 ++++++++++++++
 tb/tb_decode_execute_register.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode/execute boundary of the 24-bit core.
//   decode_ctrl_t : packed 16-bit control word produced by the control decoder
//   REG_ZERO      : architectural zero register address
//   REG_PC        : program counter register address
//   CTRL_BUBBLE   : control word of an inserted bubble (no side effects)
package decode_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       MemtoReg;
    logic       ALUSrc;
    logic       Branch;
    logic [2:0] ALUControl;
    logic [1:0] FlagWrite;
    logic [3:0] Cond;
    logic [1:0] spare;
  } decode_ctrl_t;

  localparam logic [3:0]   REG_ZERO    = 4'd0;
  localparam logic [3:0]   REG_PC      = 4'd15;
  localparam decode_ctrl_t CTRL_BUBBLE = 16'h0;

endpackage

// File: rtl/operand_bypass_mux.sv
// Combinational source-operand selection for one decode read port.
//   RA      : source register address
//   RD      : register file read data
//   PCPlus8 : value seen when reading register 15
//   WA3W    : writeback destination address
//   WD3W    : writeback data
//   WE3W    : writeback write enable
//   Operand : selected operand value
module operand_bypass_mux
  import decode_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic [3:0]   RA,
  input  logic [N-1:0] RD,
  input  logic [N-1:0] PCPlus8,
  input  logic [3:0]   WA3W,
  input  logic [N-1:0] WD3W,
  input  logic         WE3W,
  output logic [N-1:0] Operand
);

  // Zero and PC reads win over the bypass, so a writeback to r15 is never forwarded.
  always_comb begin
    Operand = RD;
    if (RA == REG_ZERO) begin
      Operand = '0;
    end else if (RA == REG_PC) begin
      Operand = PCPlus8;
    end else if (WE3W && (WA3W == RA)) begin
      Operand = WD3W;
    end
  end

endmodule

// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with stall, flush and same-edge writeback bypass.
//   clk, rst            : clock, asynchronous active-high reset
//   StallE, FlushE      : hold the stage / load a bubble (stall has priority)
//   RA1D, RA2D, WA3D    : decode source and destination addresses
//   RD1D, RD2D          : register file read data
//   ExtImmD, PCPlus8D   : extended immediate, PC+8 for r15 reads
//   CtrlD               : decoded control word
//   WA3W, WD3W, WE3W    : writeback port, used for the same-edge bypass
//   RD1E..CtrlE, ValidE : captured execute-stage contents
//   StallCount          : saturating count of stalled cycles
//   FlushCount          : saturating count of inserted bubbles
module decode_execute_register
  import decode_pkg::*;
#(
  parameter int unsigned N  = 24,
  parameter int unsigned CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallE,
  input  logic         FlushE,
  input  logic [3:0]   RA1D,
  input  logic [3:0]   RA2D,
  input  logic [3:0]   WA3D,
  input  logic [N-1:0] RD1D,
  input  logic [N-1:0] RD2D,
  input  logic [N-1:0] ExtImmD,
  input  logic [N-1:0] PCPlus8D,
  input  decode_ctrl_t CtrlD,
  input  logic [3:0]   WA3W,
  input  logic [N-1:0] WD3W,
  input  logic         WE3W,
  output logic [N-1:0] RD1E,
  output logic [N-1:0] RD2E,
  output logic [N-1:0] ExtImmE,
  output logic [3:0]   RA1E,
  output logic [3:0]   RA2E,
  output logic [3:0]   WA3E,
  output decode_ctrl_t CtrlE,
  output logic         ValidE,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

  logic [N-1:0]  op1, op2;
  logic [N-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [3:0]    ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
  decode_ctrl_t  ctrl_q, ctrl_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  operand_bypass_mux #(.N(N)) u_op1_mux (
    .RA      (RA1D),
    .RD      (RD1D),
    .PCPlus8 (PCPlus8D),
    .WA3W    (WA3W),
    .WD3W    (WD3W),
    .WE3W    (WE3W),
    .Operand (op1)
  );

  operand_bypass_mux #(.N(N)) u_op2_mux (
    .RA      (RA2D),
    .RD      (RD2D),
    .PCPlus8 (PCPlus8D),
    .WA3W    (WA3W),
    .WD3W    (WD3W),
    .WE3W    (WE3W),
    .Operand (op2)
  );

  always_comb begin
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    ra1_d       = ra1_q;
    ra2_d       = ra2_q;
    wa3_d       = wa3_q;
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallE) begin
      // Hold everything; a pending flush is dropped and not counted.
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CntOne;
    end else if (FlushE) begin
      // Zeroed addresses keep the forwarding unit from matching a bubble.
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      ra1_d   = REG_ZERO;
      ra2_d   = REG_ZERO;
      wa3_d   = REG_ZERO;
      ctrl_d  = CTRL_BUBBLE;
      valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CntOne;
    end else begin
      rd1_d   = op1;
      rd2_d   = op2;
      imm_d   = ExtImmD;
      ra1_d   = RA1D;
      ra2_d   = RA2D;
      wa3_d   = WA3D;
      ctrl_d  = CtrlD;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      wa3_q       <= '0;
      ctrl_q      <= CTRL_BUBBLE;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      wa3_q       <= wa3_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign RD1E       = rd1_q;
  assign RD2E       = rd2_q;
  assign ExtImmE    = imm_q;
  assign RA1E       = ra1_q;
  assign RA2E       = ra2_q;
  assign WA3E       = wa3_q;
  assign CtrlE      = ctrl_q;
  assign ValidE     = valid_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_decode_execute_register.sv
module tb_decode_execute_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallE, FlushE;
  logic [3:0]  RA1D, RA2D, WA3D, WA3W;
  logic [23:0] RD1D, RD2D, ExtImmD, PCPlus8D, WD3W;
  logic [15:0] CtrlD;
  logic        WE3W;

  logic [23:0] RD1E, RD2E, ExtImmE;
  logic [3:0]  RA1E, RA2E, WA3E;
  logic [15:0] CtrlE;
  logic        ValidE;
  logic [15:0] StallCount, FlushCount;

  // Narrow-counter instance for saturation; only its counters are observed.
  logic [23:0] n_rd1, n_rd2, n_imm;
  logic [3:0]  n_ra1, n_ra2, n_wa3;
  logic [15:0] n_ctrl;
  logic        n_valid;
  logic [3:0]  n_stall, n_flush;

  int checks = 0;
  int errors = 0;

  // Reference state: what the execute stage should hold.
  logic [23:0] m_rd1, m_rd2, m_imm;
  logic [3:0]  m_ra1, m_ra2, m_wa3;
  logic [15:0] m_ctrl;
  logic        m_valid;
  int          m_sc, m_fc, m_sc4, m_fc4;

  always #5 clk = ~clk;

  decode_execute_register #(.N(24), .CW(16)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RD1D(RD1D), .RD2D(RD2D),
    .ExtImmD(ExtImmD), .PCPlus8D(PCPlus8D), .CtrlD(CtrlD),
    .WA3W(WA3W), .WD3W(WD3W), .WE3W(WE3W),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .CtrlE(CtrlE), .ValidE(ValidE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  decode_execute_register #(.N(24), .CW(4)) dut_narrow (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RD1D(RD1D), .RD2D(RD2D),
    .ExtImmD(ExtImmD), .PCPlus8D(PCPlus8D), .CtrlD(CtrlD),
    .WA3W(WA3W), .WD3W(WD3W), .WE3W(WE3W),
    .RD1E(n_rd1), .RD2E(n_rd2), .ExtImmE(n_imm), .RA1E(n_ra1), .RA2E(n_ra2),
    .WA3E(n_wa3), .CtrlE(n_ctrl), .ValidE(n_valid),
    .StallCount(n_stall), .FlushCount(n_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand rule: r0 reads zero, r15 reads PC+8, else same-edge writeback wins.
  function automatic logic [23:0] operand(input logic [3:0] ra, input logic [23:0] rd);
    if (ra == 4'd0) return 24'h0;
    if (ra == 4'd15) return PCPlus8D;
    if (WE3W && WA3W == ra) return WD3W;
    return rd;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_ra1 = 0; m_ra2 = 0; m_wa3 = 0;
    m_ctrl = 0; m_valid = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
  endtask

  task automatic model_edge();
    if (StallE) begin
      m_sc  = sat_inc(m_sc, 65535);
      m_sc4 = sat_inc(m_sc4, 15);
    end else if (FlushE) begin
      m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_ra1 = 0; m_ra2 = 0; m_wa3 = 0;
      m_ctrl = 0; m_valid = 0;
      m_fc  = sat_inc(m_fc, 65535);
      m_fc4 = sat_inc(m_fc4, 15);
    end else begin
      m_rd1 = operand(RA1D, RD1D);
      m_rd2 = operand(RA2D, RD2D);
      m_imm = ExtImmD; m_ra1 = RA1D; m_ra2 = RA2D; m_wa3 = WA3D;
      m_ctrl = CtrlD; m_valid = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RD1E"}, 32'(RD1E), 32'(m_rd1));
    chk({tag, ".RD2E"}, 32'(RD2E), 32'(m_rd2));
    chk({tag, ".ExtImmE"}, 32'(ExtImmE), 32'(m_imm));
    chk({tag, ".RA1E"}, 32'(RA1E), 32'(m_ra1));
    chk({tag, ".RA2E"}, 32'(RA2E), 32'(m_ra2));
    chk({tag, ".WA3E"}, 32'(WA3E), 32'(m_wa3));
    chk({tag, ".CtrlE"}, 32'(CtrlE), 32'(m_ctrl));
    chk({tag, ".ValidE"}, 32'(ValidE), 32'(m_valid));
    chk({tag, ".StallCount"}, 32'(StallCount), 32'(m_sc));
    chk({tag, ".FlushCount"}, 32'(FlushCount), 32'(m_fc));
    chk({tag, ".StallCount4"}, 32'(n_stall), 32'(m_sc4));
    chk({tag, ".FlushCount4"}, 32'(n_flush), 32'(m_fc4));
  endtask

  // Inputs are stable at the edge; outputs are sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    StallE = 0; FlushE = 0; RA1D = 1; RA2D = 2; WA3D = 3; RD1D = 0; RD2D = 0;
    ExtImmD = 0; PCPlus8D = 0; CtrlD = 0; WA3W = 0; WD3W = 0; WE3W = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 0;

    // Load something, then reset mid-cycle: outputs must clear without an edge.
    RD1D = 24'h123456; RD2D = 24'h654321; ExtImmD = 24'h00AA55; CtrlD = 16'hF0F0;
    cycle("preload");
    #2 rst = 1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 0;
    RA1D = 4; RD1D = 24'h123456;
    cycle("post_rst");
    chk("post_rst_val", 32'(RD1E), 32'h123456);
    chk("post_rst_valid", 32'(ValidE), 32'h1);

    // Same-edge bypass, then the same stimulus without write enable.
    RA1D = 5; RD1D = 24'h000111; WE3W = 1; WA3W = 5; WD3W = 24'hABCDEF;
    cycle("bypass");
    chk("bypass_rd1", 32'(RD1E), 32'hABCDEF);
    WE3W = 0;
    cycle("no_bypass");
    chk("no_bypass_rd1", 32'(RD1E), 32'h000111);

    // Register 0 and register 15 are never bypassed.
    RA2D = 0; RD2D = 24'hFFFFFF; WE3W = 1; WA3W = 0;
    cycle("r0");
    chk("r0_rd2", 32'(RD2E), 32'h0);
    RA1D = 15; PCPlus8D = 24'h000108; WA3W = 15; WD3W = 24'h777777;
    cycle("r15");
    chk("r15_rd1", 32'(RD1E), 32'h000108);

    // Both operands bypass from one writeback.
    RA1D = 7; RA2D = 7; RD1D = 24'h1; RD2D = 24'h2; WA3W = 7; WD3W = 24'h5A5A5A;
    cycle("dual");
    chk("dual_rd2", 32'(RD2E), 32'h5A5A5A);
    WE3W = 0;

    // Stall beats flush; flush then bubbles.
    CtrlD = 16'h8000; WA3D = 9;
    cycle("ctrl_load");
    StallE = 1; FlushE = 1; CtrlD = 16'h1234; WA3D = 2;
    for (int i = 0; i < 3; i++) cycle("stall_flush");
    chk("stall_ctrl", 32'(CtrlE), 32'h8000);
    chk("stall_cnt3", 32'(StallCount), 32'd3);
    chk("stall_fcnt0", 32'(FlushCount), 32'd0);
    StallE = 0;
    cycle("flush");
    chk("flush_ctrl", 32'(CtrlE), 32'h0);
    chk("flush_wa3", 32'(WA3E), 32'h0);
    chk("flush_valid", 32'(ValidE), 32'h0);
    chk("flush_cnt1", 32'(FlushCount), 32'd1);
    FlushE = 0;

    // Back-to-back loads appear one cycle later in order.
    for (int i = 0; i < 3; i++) begin
      WA3D = 4'(4 + i);
      CtrlD = 16'h1100 + 16'(i);
      cycle("b2b");
      chk("b2b_wa3", 32'(WA3E), 32'(4 + i));
      chk("b2b_ctrl", 32'(CtrlE), 32'h1100 + 32'(i));
    end

    // Saturation of the 4-bit counters from a clean reset.
    @(negedge clk) rst = 1;
    #1 model_reset();
    @(negedge clk) rst = 0;
    StallE = 1;
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat_stall4", 32'(n_stall), 32'hF);
    chk("sat_stall16", 32'(StallCount), 32'd20);
    StallE = 0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      StallE   = ($urandom_range(0, 4) == 0);
      FlushE   = ($urandom_range(0, 3) == 0);
      RA1D     = 4'($urandom);
      RA2D     = 4'($urandom);
      WA3D     = 4'($urandom);
      RD1D     = 24'($urandom);
      RD2D     = 24'($urandom);
      ExtImmD  = 24'($urandom);
      PCPlus8D = 24'($urandom);
      CtrlD    = 16'($urandom);
      WE3W     = 1'($urandom);
      WA3W     = ($urandom_range(0, 2) == 0) ? RA1D :
                 ($urandom_range(0, 1) == 0) ? RA2D : 4'($urandom);
      WD3W     = 24'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
